branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Purpose : direct-mapped branch target buffer with 2-bit saturating direction
//           counters, zero-latency fetch lookup, execute-stage update and a
//           saturating mispredict statistics counter.
// Latency : lookup is combinational (0 cycles); updates land on the next CLK edge.
// Backpressure: none -- one lookup and at most one update are accepted per cycle.
// Ports   : CLK/Reset_n            clock, async active-low reset
//           PC_F -> Hit_F, PrPCSrc_F, PrALUResult_F   fetch lookup
//           Update_E, PC_E, PCSrc_E, ALUResult_E,
//           PrPCSrc_E, PrALUResult_E                  resolved-branch update
//           Flush                  synchronous invalidate of all entries
//           MispredictCount        saturating mispredict count
module branch_target_buffer #(
  parameter int ENTRY_BITS = 4,
  parameter int TAG_BITS   = 8,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [31:0]      PC_F,
  output logic             PrPCSrc_F,
  output logic [31:0]      PrALUResult_F,
  output logic             Hit_F,
  input  logic             Update_E,
  input  logic [31:0]      PC_E,
  input  logic             PCSrc_E,
  input  logic [31:0]      ALUResult_E,
  input  logic             PrPCSrc_E,
  input  logic [31:0]      PrALUResult_E,
  input  logic             Flush,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_LO  = ENTRY_BITS + 2;
  localparam int TAG_HI  = ENTRY_BITS + TAG_BITS + 1;

  // Entry storage
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Index/tag decode; PC bits [1:0] never participate
  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;

  assign idx_f = PC_F[ENTRY_BITS+1:2];
  assign tag_f = PC_F[TAG_HI:TAG_LO];
  assign idx_e = PC_E[ENTRY_BITS+1:2];
  assign tag_e = PC_E[TAG_HI:TAG_LO];

  // PC_E bits outside index/tag are intentionally ignored; fold them into a
  // sink so the unused-bit intent is explicit and parameter-independent.
  logic unused_pc_e;
  assign unused_pc_e = ^PC_E;

  // Fetch lookup reads the registered state only, so a same-cycle update to
  // the same index is not visible until the following cycle.
  always_comb begin
    Hit_F         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PrPCSrc_F     = Hit_F && ctr_q[idx_f][1];
    PrALUResult_F = PrPCSrc_F ? target_q[idx_f] : (PC_F + 32'd4);
  end

  // Execute-stage update decode
  logic        hit_e;
  logic        wr_en;
  logic [1:0]  ctr_e_d;
  logic [31:0] tgt_e_d;
  logic        mispredict;

  always_comb begin
    hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    // A hit always rewrites the entry (counter moves); a miss only allocates
    // when taken. Flush overrides any entry write in the same cycle.
    wr_en = Update_E && !Flush && (hit_e || PCSrc_E);

    ctr_e_d = ctr_q[idx_e];
    if (hit_e) begin
      if (PCSrc_E) begin
        if (ctr_q[idx_e] != 2'b11) ctr_e_d = ctr_q[idx_e] + 2'b01;
      end else begin
        if (ctr_q[idx_e] != 2'b00) ctr_e_d = ctr_q[idx_e] - 2'b01;
      end
    end else begin
      ctr_e_d = 2'b10;  // fresh allocation starts weakly taken
    end

    tgt_e_d = PCSrc_E ? ALUResult_E : target_q[idx_e];

    // Statistics count regardless of Flush
    mispredict = Update_E &&
                 ((PrPCSrc_E != PCSrc_E) ||
                  (PCSrc_E && (PrALUResult_E != ALUResult_E)));

    cnt_d = cnt_q;
    if (mispredict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (Flush) begin
        // Only valid bits clear; counters and targets survive a flush
        for (int i = 0; i < ENTRIES; i++) begin
          valid_q[i] <= 1'b0;
        end
      end else if (wr_en) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= tgt_e_d;
        ctr_q[idx_e]    <= ctr_e_d;
      end
    end
  end

  assign MispredictCount = cnt_q;

endmodule
